// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: demand-actuated two-approach signal controller with a pedestrian walk phase
module traffic_phase_scheduler #(
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 10,
  parameter int YELLOW    = 2,
  parameter int ALL_RED   = 1,
  parameter int WALK      = 5,
  parameter int CW        = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       sense_a,
  input  logic       sense_b,
  input  logic       ped_btn,
  output logic [2:0] light_A,
  output logic [2:0] light_B,
  output logic       walk,
  output logic [2:0] phase
);
  typedef enum logic [2:0] {A_GRN, A_YEL, A_CLR, B_GRN, B_YEL, B_CLR, PED} state_t;
  localparam logic [CW:0]   L_MIN  = (CW+1)'(MIN_GREEN);
  localparam logic [CW:0]   L_MAX  = (CW+1)'(MAX_GREEN);
  localparam logic [CW:0]   L_YEL  = (CW+1)'(YELLOW);
  localparam logic [CW:0]   L_CLR  = (CW+1)'(ALL_RED);
  localparam logic [CW:0]   L_WALK = (CW+1)'(WALK);
  localparam logic [CW-1:0] L_CMAX = CW'(MAX_GREEN);
  state_t        r_state, w_next;
  logic [CW-1:0] r_ctr;
  logic [CW:0]   w_elapsed;
  logic          r_req_a, r_req_b, r_ped, r_last_b, w_last_b;
  logic          w_chg, w_enter_a, w_enter_b, w_enter_p;
  assign w_elapsed = {1'b0, r_ctr} + 1'b1;
  assign w_chg     = w_next != r_state;
  assign w_enter_a = w_next == A_GRN && r_state != A_GRN;
  assign w_enter_b = w_next == B_GRN && r_state != B_GRN;
  assign w_enter_p = w_next == PED && r_state != PED;
  // next phase: timed exits on tick cycles, greens yield only to conflicting demand
  always_comb begin
    w_next   = r_state;
    w_last_b = r_last_b;
    case (r_state)
      A_GRN: if (tick && (r_req_b || r_ped) && (w_elapsed >= L_MAX || (w_elapsed >= L_MIN && !sense_a))) w_next = A_YEL;
      A_YEL: if (tick && w_elapsed >= L_YEL) w_next = A_CLR;
      A_CLR: if (tick && w_elapsed >= L_CLR) begin
        w_next   = r_ped ? PED : B_GRN;
        w_last_b = 1'b0;
      end
      B_GRN: if (tick && (r_req_a || r_ped) && (w_elapsed >= L_MAX || (w_elapsed >= L_MIN && !sense_b))) w_next = B_YEL;
      B_YEL: if (tick && w_elapsed >= L_YEL) w_next = B_CLR;
      B_CLR: if (tick && w_elapsed >= L_CLR) begin
        w_next   = r_ped ? PED : A_GRN;
        w_last_b = 1'b1;
      end
      PED:   if (tick && w_elapsed >= L_WALK) w_next = r_last_b ? A_GRN : B_GRN;
      default: w_next = A_GRN;
    endcase
  end
  // phase register, saturating tick timer and demand latches (entry clear beats a new request)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= A_GRN;
      r_ctr    <= '0;
      r_req_a  <= 1'b0;
      r_req_b  <= 1'b0;
      r_ped    <= 1'b0;
      r_last_b <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_ctr    <= w_chg ? '0 : !tick ? r_ctr : r_ctr == L_CMAX ? r_ctr : r_ctr + 1'b1;
      r_req_a  <= !w_enter_a && (r_req_a || (sense_a && r_state != A_GRN));
      r_req_b  <= !w_enter_b && (r_req_b || (sense_b && r_state != B_GRN));
      r_ped    <= !w_enter_p && (r_ped || (ped_btn && r_state != PED));
      r_last_b <= w_last_b;
    end
  end
  // lamp decode straight from the phase register
  always_comb begin
    light_A = r_state == A_GRN ? 3'b001 : r_state == A_YEL ? 3'b010 : 3'b100;
    light_B = r_state == B_GRN ? 3'b001 : r_state == B_YEL ? 3'b010 : 3'b100;
    walk    = r_state == PED;
    phase   = r_state;
  end
endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb_traffic_phase_scheduler: directed sequences plus randomized traffic against a phase-level reference model
module tb_traffic_phase_scheduler;
  localparam int MING = 4, MAXG = 10, YEL = 2, CLR = 1, WLK = 5;
  localparam int AG = 0, AY = 1, AC = 2, BG = 3, BY = 4, BC = 5, PD = 6;
  logic       clk = 0, reset = 0, tick = 0, sense_a = 0, sense_b = 0, ped_btn = 0;
  logic [2:0] light_A, light_B, phase;
  logic       walk;
  logic       d_sa = 0, d_sb = 0, d_pb = 0;
  int         n_cmp = 0, n_err = 0;
  int         m_ph = AG, m_t = 0;
  bit         m_ra = 0, m_rb = 0, m_pp = 0, m_lb = 0;

  traffic_phase_scheduler #(.MIN_GREEN(MING), .MAX_GREEN(MAXG), .YELLOW(YEL), .ALL_RED(CLR), .WALK(WLK), .CW(4)) dut (
    .clk(clk), .reset(reset), .tick(tick), .sense_a(sense_a), .sense_b(sense_b), .ped_btn(ped_btn),
    .light_A(light_A), .light_B(light_B), .walk(walk), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int dur(input int ph);
    return (ph == AY || ph == BY) ? YEL : (ph == AC || ph == BC) ? CLR : (ph == PD) ? WLK : MING;
  endfunction

  function automatic int lamp_a(input int ph);
    return ph == AG ? 1 : ph == AY ? 2 : 4;
  endfunction

  function automatic int lamp_b(input int ph);
    return ph == BG ? 1 : ph == BY ? 2 : 4;
  endfunction

  task automatic model(input bit rs, input bit tk, input bit sa, input bit sb, input bit pb);
    int  nph, e;
    bit  on_b, own, conf;
    if (rs) begin
      m_ph = AG; m_t = 0; m_ra = 0; m_rb = 0; m_pp = 0; m_lb = 0;
      return;
    end
    nph = m_ph;
    if (tk) begin
      e    = m_t + 1;
      on_b = m_ph >= BG && m_ph <= BC;
      own  = on_b ? sb : sa;
      conf = (on_b ? m_ra : m_rb) || m_pp;
      if (m_ph == AG || m_ph == BG) begin
        if (conf && (e >= MAXG || (e >= MING && !own))) nph = m_ph + 1;
      end else if (e >= dur(m_ph)) begin
        if (m_ph == PD) nph = m_lb ? AG : BG;
        else if (m_ph == AC || m_ph == BC) begin
          nph  = m_pp ? PD : (on_b ? AG : BG);
          m_lb = on_b;
        end else nph = m_ph + 1;
      end
    end
    m_ra = !(nph == AG && m_ph != AG) && (m_ra || (sa && m_ph != AG));
    m_rb = !(nph == BG && m_ph != BG) && (m_rb || (sb && m_ph != BG));
    m_pp = !(nph == PD && m_ph != PD) && (m_pp || (pb && m_ph != PD));
    m_t  = nph != m_ph ? 0 : tk ? m_t + 1 : m_t;
    m_ph = nph;
  endtask

  task automatic step(input logic rs, input logic tk);
    reset = rs; tick = tk; sense_a = d_sa; sense_b = d_sb; ped_btn = d_pb;
    @(posedge clk);
    model(rs, tk, d_sa, d_sb, d_pb);
    @(negedge clk);
    check("light_A", int'(light_A), lamp_a(m_ph));
    check("light_B", int'(light_B), lamp_b(m_ph));
    check("walk", int'(walk), int'(m_ph == PD));
  endtask

  function automatic logic [6:0] sig();
    return {light_A, light_B, walk};
  endfunction

  task automatic ticks_to_change(input string tag, input int exp_n, input logic [6:0] exp_sig);
    logic [6:0] s0;
    int n;
    s0 = sig();
    n = 0;
    while (sig() == s0 && n < 40) begin
      step(0, 1);
      n++;
      step(0, 0);
    end
    check({tag, "_ticks"}, n, exp_n);
    check({tag, "_lamps"}, int'(sig()), int'(exp_sig));
  endtask

  task automatic pulse(input bit a, input bit b, input bit p);
    d_sa = d_sa | a; d_sb = d_sb | b; d_pb = p;
    step(0, 0);
    d_sa = d_sa & ~a; d_sb = d_sb & ~b; d_pb = 0;
  endtask

  initial begin
    @(negedge clk);
    step(1, 0);
    step(1, 1);
    check("rst_A", int'(light_A), 1);
    check("rst_B", int'(light_B), 4);
    check("rst_walk", int'(walk), 0);
    for (int i = 0; i < 20; i++) begin step(0, 1); step(0, 0); end
    check("idle20", int'(sig()), int'({3'b001, 3'b100, 1'b0}));
    step(1, 0);
    pulse(0, 1, 0);
    ticks_to_change("t2_grn", 4, {3'b010, 3'b100, 1'b0});
    ticks_to_change("t2_yel", 2, {3'b100, 3'b100, 1'b0});
    ticks_to_change("t2_clr", 1, {3'b100, 3'b001, 1'b0});
    step(1, 0);
    d_sa = 1;
    pulse(0, 1, 0);
    ticks_to_change("t3_grn", 10, {3'b010, 3'b100, 1'b0});
    ticks_to_change("t3_yel", 2, {3'b100, 3'b100, 1'b0});
    ticks_to_change("t3_clr", 1, {3'b100, 3'b001, 1'b0});
    d_sa = 0;
    pulse(1, 0, 0);
    ticks_to_change("t5_bgrn", 4, {3'b100, 3'b010, 1'b0});
    step(1, 0);
    check("t5_rst", int'(sig()), int'({3'b001, 3'b100, 1'b0}));
    for (int i = 0; i < 12; i++) begin step(0, 1); step(0, 0); end
    check("t5_latches", int'(sig()), int'({3'b001, 3'b100, 1'b0}));
    step(1, 0);
    pulse(0, 0, 1);
    ticks_to_change("t4_grn", 4, {3'b010, 3'b100, 1'b0});
    ticks_to_change("t4_yel", 2, {3'b100, 3'b100, 1'b0});
    ticks_to_change("t4_clr", 1, {3'b100, 3'b100, 1'b1});
    ticks_to_change("t4_walk", 5, {3'b100, 3'b001, 1'b0});
    step(1, 0);
    d_sb = 1;
    for (int i = 0; i < 50; i++) step(0, 0);
    check("t6_hold", int'(sig()), int'({3'b001, 3'b100, 1'b0}));
    d_sb = 0;
    ticks_to_change("t6_req", 4, {3'b010, 3'b100, 1'b0});
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) d_sa = ~d_sa;
      if ($urandom_range(0, 7) == 0) d_sb = ~d_sb;
      d_pb = $urandom_range(0, 29) == 0;
      step($urandom_range(0, 599) == 0, $urandom_range(0, 2) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
